lowx_mem_arbiter: RTL and testbench

LOWX_MEM_ARBITER -- requirements
Module: lowx_mem_arbiter

---
 rtl/lowx_mem_arbiter.sv | 170 +++++++++++++++++
 tb/tb_lowx_mem_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lowx_mem_arbiter.sv
// Round-robin arbiter that multiplexes icache line fills and dcache fills/write-backs
// onto one memory port. Each grant runs REQ -> WAIT -> RESP, with a timeout on REQ and WAIT.
module lowx_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int BLK_W   = 128,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ireq_valid_i,
  input  logic [ADDR_W-1:0] ireq_addr_i,
  input  logic              dreq_valid_i,
  input  logic [ADDR_W-1:0] dreq_addr_i,
  input  logic              dreq_rw_i,
  input  logic [BLK_W-1:0]  dreq_data_i,
  output logic              ires_valid_o,
  output logic [BLK_W-1:0]  ires_data_o,
  output logic              dres_valid_o,
  output logic [BLK_W-1:0]  dres_data_o,
  output logic              res_err_o,
  output logic              mem_req_valid_o,
  input  logic              mem_req_ready_i,
  output logic [ADDR_W-1:0] mem_req_addr_o,
  output logic              mem_req_rw_o,
  output logic [BLK_W-1:0]  mem_req_data_o,
  input  logic              mem_res_valid_i,
  input  logic [BLK_W-1:0]  mem_res_data_i,
  output logic              busy_o
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_RESP
  } state_e;

  state_e             state_q, state_d;
  logic               gnt_d_q, gnt_d_d;   // granted requester is the dcache
  logic               last_d_q, last_d_d; // most recent grant went to the dcache
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               rw_q, rw_d;
  logic [BLK_W-1:0]   data_q, data_d;

  logic               pick_d;
  logic               req_v;
  logic               res_v;
  logic               res_err;
  logic [BLK_W-1:0]   res_data;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      gnt_d_q  <= 1'b0;
      last_d_q <= 1'b0;
      cnt_q    <= '0;
      addr_q   <= '0;
      rw_q     <= 1'b0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      gnt_d_q  <= gnt_d_d;
      last_d_q <= last_d_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      rw_q     <= rw_d;
      data_q   <= data_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_d_d  = gnt_d_q;
    last_d_d = last_d_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    rw_d     = rw_q;
    data_d   = data_q;
    pick_d   = 1'b0;
    req_v    = 1'b0;
    res_v    = 1'b0;
    res_err  = 1'b0;
    res_data = '0;

    case (state_q)
      S_IDLE: begin
        if (ireq_valid_i || dreq_valid_i) begin
          // On contention the dcache wins unless it held the previous grant.
          pick_d   = dreq_valid_i && (!ireq_valid_i || !last_d_q);
          gnt_d_d  = pick_d;
          last_d_d = pick_d;
          cnt_d    = '0;
          state_d  = S_REQ;
          if (pick_d) begin
            addr_d = dreq_addr_i;
            rw_d   = dreq_rw_i;
            data_d = dreq_data_i;
          end else begin
            addr_d = ireq_addr_i;
            rw_d   = 1'b0;
            data_d = '0;
          end
        end
      end
      S_REQ: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          res_v   = 1'b1;
          res_err = 1'b1;
          state_d = S_RESP;
        end else begin
          req_v = 1'b1;
          if (mem_req_ready_i) begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A response arriving on the timeout cycle is delivered as a normal response.
        if (mem_res_valid_i) begin
          res_v    = 1'b1;
          res_data = mem_res_data_i;
          state_d  = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          res_v   = 1'b1;
          res_err = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are forced low while reset is asserted, even before the state register clears.
  always_comb begin
    ires_valid_o    = 1'b0;
    ires_data_o     = '0;
    dres_valid_o    = 1'b0;
    dres_data_o     = '0;
    res_err_o       = 1'b0;
    mem_req_valid_o = 1'b0;
    mem_req_addr_o  = '0;
    mem_req_rw_o    = 1'b0;
    mem_req_data_o  = '0;
    busy_o          = 1'b0;
    if (!rst_i) begin
      ires_valid_o    = res_v && !gnt_d_q;
      dres_valid_o    = res_v && gnt_d_q;
      ires_data_o     = (res_v && !gnt_d_q) ? res_data : '0;
      dres_data_o     = (res_v && gnt_d_q) ? res_data : '0;
      res_err_o       = res_err;
      mem_req_valid_o = req_v;
      mem_req_addr_o  = addr_q;
      mem_req_rw_o    = rw_q;
      mem_req_data_o  = data_q;
      busy_o          = (state_q != S_IDLE);
    end
  end

endmodule

// File: tb/tb_lowx_mem_arbiter.sv
// Directed bench for lowx_mem_arbiter: stimulus queues expected memory requests and
// responses; a negedge monitor pops and compares whenever the DUT presents them.
module tb_lowx_mem_arbiter;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         ireq_valid_i;
  logic [31:0]  ireq_addr_i;
  logic         dreq_valid_i;
  logic [31:0]  dreq_addr_i;
  logic         dreq_rw_i;
  logic [127:0] dreq_data_i;
  logic         ires_valid_o;
  logic [127:0] ires_data_o;
  logic         dres_valid_o;
  logic [127:0] dres_data_o;
  logic         res_err_o;
  logic         mem_req_valid_o;
  logic         mem_req_ready_i;
  logic [31:0]  mem_req_addr_o;
  logic         mem_req_rw_o;
  logic [127:0] mem_req_data_o;
  logic         mem_res_valid_i;
  logic [127:0] mem_res_data_i;
  logic         busy_o;

  lowx_mem_arbiter #(.ADDR_W(32), .BLK_W(128), .TIMEOUT(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ireq_valid_i(ireq_valid_i), .ireq_addr_i(ireq_addr_i),
    .dreq_valid_i(dreq_valid_i), .dreq_addr_i(dreq_addr_i),
    .dreq_rw_i(dreq_rw_i), .dreq_data_i(dreq_data_i),
    .ires_valid_o(ires_valid_o), .ires_data_o(ires_data_o),
    .dres_valid_o(dres_valid_o), .dres_data_o(dres_data_o),
    .res_err_o(res_err_o),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_req_addr_o(mem_req_addr_o), .mem_req_rw_o(mem_req_rw_o),
    .mem_req_data_o(mem_req_data_o),
    .mem_res_valid_i(mem_res_valid_i), .mem_res_data_i(mem_res_data_i),
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_err = 0;

  // {addr, rw, data} and {is_dcache, data, err}
  logic [160:0] exp_mreq[$];
  logic [129:0] exp_res[$];

  task automatic check(input string name, input logic [199:0] act, input logic [199:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [40:0] all_outs();
    return {busy_o, mem_req_valid_o, ires_valid_o, dres_valid_o, res_err_o, mem_req_rw_o,
            mem_req_addr_o, |mem_req_data_o, |ires_data_o, |dres_data_o};
  endfunction

  always @(negedge clk_i) begin
    if (ires_valid_o || dres_valid_o) begin
      check("res_one_hot", {1'b0, ires_valid_o & dres_valid_o}, 0);
      if (exp_res.size() == 0) begin
        check("res_unexpected", {ires_valid_o, dres_valid_o}, 0);
      end else begin
        check("res", {dres_valid_o, (dres_valid_o ? dres_data_o : ires_data_o), res_err_o},
              exp_res.pop_front());
        check("res_other_data_zero", (dres_valid_o ? ires_data_o : dres_data_o), 0);
      end
    end else if (res_err_o || (|ires_data_o) || (|dres_data_o)) begin
      check("res_idle_zero", {res_err_o, |ires_data_o, |dres_data_o}, 0);
    end
    if (mem_req_valid_o && mem_req_ready_i) begin
      if (exp_mreq.size() == 0)
        check("mreq_unexpected", {mem_req_addr_o, mem_req_rw_o}, 0);
      else
        check("mreq", {mem_req_addr_o, mem_req_rw_o, mem_req_data_o}, exp_mreq.pop_front());
    end
  end

  task automatic do_reset();
    rst_i = 1'b1;
    mem_req_ready_i = 1'b0;
    mem_res_valid_i = 1'b0;
    repeat (2) begin
      tick();
      check("reset_outs_zero", all_outs(), 0);
    end
    ireq_valid_i = 1'b0;
    dreq_valid_i = 1'b0;
    rst_i = 1'b0;
    tick();
    check("post_reset_outs_zero", all_outs(), 0);
  endtask

  // Called in the IDLE cycle where the request under test is granted; returns in IDLE.
  task automatic do_txn(input logic is_d, input logic [31:0] a, input logic rw,
                        input logic [127:0] wd, input logic [127:0] rd,
                        input int ready_dly, input int res_dly);
    exp_mreq.push_back({a, rw, wd});
    exp_res.push_back({is_d, rd, 1'b0});
    tick();
    if (is_d) begin
      dreq_addr_i = ~dreq_addr_i;
      dreq_data_i = ~dreq_data_i;
      dreq_rw_i   = ~dreq_rw_i;
    end else begin
      ireq_addr_i = ~ireq_addr_i;
    end
    for (int i = 0; i < ready_dly; i++) begin
      check("req_hold", {mem_req_valid_o, mem_req_addr_o, mem_req_rw_o, mem_req_data_o},
            {1'b1, a, rw, wd});
      mem_res_valid_i = 1'b1;
      mem_res_data_i  = 128'hBAD0 + 128'(i);
      tick();
    end
    check("req_valid", {1'b0, mem_req_valid_o}, 1);
    mem_res_valid_i = 1'b0;
    mem_req_ready_i = 1'b1;
    tick();
    mem_req_ready_i = 1'b0;
    check("wait_state", {busy_o, mem_req_valid_o}, 2'b10);
    repeat (res_dly) tick();
    mem_res_valid_i = 1'b1;
    mem_res_data_i  = rd;
    tick();
    mem_res_valid_i = 1'b0;
    if (is_d) dreq_valid_i = 1'b0;
    else ireq_valid_i = 1'b0;
    check("resp_busy", {1'b0, busy_o}, 1);
    tick();
    check("idle_not_busy", {1'b0, busy_o}, 0);
  endtask

  initial begin
    rst_i = 1'b1;
    ireq_valid_i = 1'b1; ireq_addr_i = 32'h1234_5678;
    dreq_valid_i = 1'b1; dreq_addr_i = 32'h9ABC_DEF0; dreq_rw_i = 1'b1;
    dreq_data_i = 128'hFFFF; mem_req_ready_i = 1'b0; mem_res_valid_i = 1'b0;
    mem_res_data_i = '0;
    do_reset();

    // Single icache fill, response 0xA5 at cycle 3
    ireq_valid_i = 1'b1; ireq_addr_i = 32'h8000_0040;
    do_txn(1'b0, 32'h8000_0040, 1'b0, 128'h0, 128'hA5, 0, 1);

    // Contention after reset: D first, then I
    do_reset();
    ireq_valid_i = 1'b1; ireq_addr_i = 32'h0000_1000;
    dreq_valid_i = 1'b1; dreq_addr_i = 32'h0000_2000; dreq_rw_i = 1'b0;
    dreq_data_i = 128'h77;
    do_txn(1'b1, 32'h0000_2000, 1'b0, 128'h77, 128'h11, 0, 0);
    do_txn(1'b0, 32'h0000_1000, 1'b0, 128'h0, 128'h22, 0, 0);

    // D write-back with ready held low for 5 cycles
    dreq_valid_i = 1'b1; dreq_addr_i = 32'hCAFE_0080; dreq_rw_i = 1'b1;
    dreq_data_i = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
    do_txn(1'b1, 32'hCAFE_0080, 1'b1, 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF,
           128'h33, 5, 0);

    // Contention with D granted last: I wins, then D
    ireq_valid_i = 1'b1; ireq_addr_i = 32'h0000_3000;
    dreq_valid_i = 1'b1; dreq_addr_i = 32'h0000_4000; dreq_rw_i = 1'b0;
    dreq_data_i = 128'h5;
    do_txn(1'b0, 32'h0000_3000, 1'b0, 128'h0, 128'h44, 1, 2);
    do_txn(1'b1, 32'h0000_4000, 1'b0, 128'h5, 128'h55, 0, 3);

    // Timeout in WAIT: error pulse 8 cycles after grant, late response ignored
    dreq_valid_i = 1'b1; dreq_addr_i = 32'h3000_0000; dreq_rw_i = 1'b0;
    dreq_data_i = 128'h6;
    exp_mreq.push_back({32'h3000_0000, 1'b0, 128'h6});
    exp_res.push_back({1'b1, 128'h0, 1'b1});
    tick();
    mem_req_ready_i = 1'b1;
    tick();
    mem_req_ready_i = 1'b0;
    repeat (6) tick();
    check("tmo_wait_pulse", {dres_valid_o, res_err_o, mem_req_valid_o}, 3'b110);
    tick();
    dreq_valid_i = 1'b0;
    mem_res_valid_i = 1'b1; mem_res_data_i = 128'h55AA;
    tick();
    tick();
    mem_res_valid_i = 1'b0;
    check("tmo_wait_idle", {1'b0, busy_o}, 0);

    // Timeout in REQ: ready never arrives, request drops on the error cycle
    ireq_valid_i = 1'b1; ireq_addr_i = 32'h4000_0000;
    exp_res.push_back({1'b0, 128'h0, 1'b1});
    repeat (7) tick();
    check("tmo_req_still_valid", {1'b0, mem_req_valid_o}, 1);
    tick();
    check("tmo_req_pulse", {ires_valid_o, res_err_o, mem_req_valid_o}, 3'b110);
    tick();
    ireq_valid_i = 1'b0;
    tick();
    check("tmo_req_idle", {1'b0, busy_o}, 0);

    // Response on the same cycle as the timeout: normal response wins
    dreq_valid_i = 1'b1; dreq_addr_i = 32'h6000_0000; dreq_rw_i = 1'b1;
    dreq_data_i = 128'h66;
    do_txn(1'b1, 32'h6000_0000, 1'b1, 128'h66, 128'h88, 2, 4);

    // Reset while in WAIT on a D request; later response ignored; pointer restored
    dreq_valid_i = 1'b1; dreq_addr_i = 32'h5000_0000; dreq_rw_i = 1'b0;
    dreq_data_i = 128'h9;
    exp_mreq.push_back({32'h5000_0000, 1'b0, 128'h9});
    tick();
    mem_req_ready_i = 1'b1;
    tick();
    mem_req_ready_i = 1'b0;
    rst_i = 1'b1;
    dreq_valid_i = 1'b0;
    #1;
    check("rst_in_wait_outs_zero", all_outs(), 0);
    tick();
    rst_i = 1'b0;
    check("rst_in_wait_cleared", all_outs(), 0);
    tick();
    mem_res_valid_i = 1'b1; mem_res_data_i = 128'h99;
    tick();
    mem_res_valid_i = 1'b0;
    check("rst_late_res_idle", {1'b0, busy_o}, 0);
    ireq_valid_i = 1'b1; ireq_addr_i = 32'h0000_7000;
    dreq_valid_i = 1'b1; dreq_addr_i = 32'h0000_8000; dreq_rw_i = 1'b0;
    dreq_data_i = 128'hA;
    do_txn(1'b1, 32'h0000_8000, 1'b0, 128'hA, 128'hD1, 0, 0);
    do_txn(1'b0, 32'h0000_7000, 1'b0, 128'h0, 128'hD2, 0, 0);

    tick();
    check("res_queue_drained", 200'(exp_res.size()), 0);
    check("mreq_queue_drained", 200'(exp_mreq.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
